// File: rtl/risc_pkg.sv
// Shared constants for the RiSC-16 core with kernel/user modes.
// Opcodes, JALR sub-ops, trap causes, status bits and control-register slots.
package risc_pkg;

    localparam int          MEM_WORDS = 65536;
    localparam logic [15:0] USER_BASE = 16'h0300;

    typedef enum logic [2:0] {
        OP_ADD, OP_ADDI, OP_NAND, OP_LUI,
        OP_SW,  OP_LW,   OP_BEQ,  OP_JALR
    } opcode_e;

    typedef enum logic [2:0] {
        C_NONE  = 3'd0,
        C_TRAP  = 3'd1,
        C_ILL   = 3'd2,
        C_PROT  = 3'd3,
        C_TIMER = 3'd4
    } cause_e;

    localparam logic [6:0] SUB_JALR = 7'h00;
    localparam logic [6:0] SUB_TRAP = 7'h01;
    localparam logic [6:0] SUB_RFE  = 7'h02;
    localparam logic [6:0] SUB_MFC  = 7'h03;
    localparam logic [6:0] SUB_MTC  = 7'h04;
    localparam logic [6:0] SUB_HALT = 7'h7F;

    localparam int ST_K   = 0;
    localparam int ST_IE  = 1;
    localparam int ST_PK  = 2;
    localparam int ST_PIE = 3;

    localparam logic [2:0] CR_STATUS = 3'd0;
    localparam logic [2:0] CR_EPC    = 3'd1;
    localparam logic [2:0] CR_CAUSE  = 3'd2;
    localparam logic [2:0] CR_TIMER  = 3'd4;
    localparam logic [2:0] CR_HVEC   = 3'd5;

    function automatic logic [15:0] sext7(input logic [6:0] v);
        return {{9{v[6]}}, v};
    endfunction

endpackage

// File: rtl/risc_mem.sv
// Unified word-addressed instruction/data memory.
// Two combinational read ports, one write port at posedge.
module risc_mem #(
    parameter int WORDS = 65536
) (
    input  logic        clk,
    input  logic [15:0] iaddr,
    output logic [15:0] idata,
    input  logic [15:0] daddr,
    output logic [15:0] ddata,
    input  logic        we,
    input  logic [15:0] wdata
);

    logic [15:0] m [0:WORDS-1];

    assign idata = m[iaddr];
    assign ddata = m[daddr];

    always_ff @(posedge clk) begin
        if (we) m[daddr] <= wdata;
    end

endmodule

// File: rtl/risc_regfile.sv
// General registers r0-r7, control registers cr0-cr7 and the countdown timer.
// Exception entry and RFE rewrite the status word here so all cr state lives in one place.
module risc_regfile
    import risc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  ra1,
    output logic [15:0] rd1,
    input  logic [2:0]  ra2,
    output logic [15:0] rd2,
    input  logic        we,
    input  logic [2:0]  wa,
    input  logic [15:0] wd,
    input  logic [2:0]  cr_ra,
    output logic [15:0] cr_rd,
    input  logic        cr_we,
    input  logic [2:0]  cr_wa,
    input  logic [15:0] cr_wd,
    input  logic        exc,
    input  cause_e      cause,
    input  logic [15:0] epc,
    input  logic        rfe,
    output logic        kmode,
    output logic        ie,
    output logic [15:0] epc_q,
    output logic [15:0] hvec,
    output logic        pend
);

    logic [15:0] r  [0:7];
    logic [15:0] cr [0:7];
    logic        tick;

    assign rd1   = (ra1 == 3'd0) ? 16'd0 : r[ra1];
    assign rd2   = (ra2 == 3'd0) ? 16'd0 : r[ra2];
    assign cr_rd = cr[cr_ra];
    assign kmode = cr[CR_STATUS][ST_K];
    assign ie    = cr[CR_STATUS][ST_IE];
    assign epc_q = cr[CR_EPC];
    assign hvec  = cr[CR_HVEC];

    // An MTC to the timer in the same cycle cancels the expiry.
    assign tick = (cr[CR_TIMER] == 16'd1) &&
                  !(cr_we && cr_wa == CR_TIMER);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                r[i]  <= 16'd0;
                cr[i] <= 16'd0;
            end
            cr[CR_STATUS] <= 16'h0001;
            pend          <= 1'b0;
        end else begin
            if (we && wa != 3'd0) r[wa] <= wd;
            if (cr[CR_TIMER] != 16'd0)
                cr[CR_TIMER] <= cr[CR_TIMER] - 16'd1;
            if (cr_we) cr[cr_wa] <= cr_wd;
            if (exc) begin
                cr[CR_EPC]    <= epc;
                cr[CR_CAUSE]  <= {13'd0, cause};
                cr[CR_STATUS] <= {cr[CR_STATUS][15:4],
                                  cr[CR_STATUS][ST_IE],
                                  cr[CR_STATUS][ST_K], 2'b01};
            end
            if (rfe)
                cr[CR_STATUS] <= {cr[CR_STATUS][15:2],
                                  cr[CR_STATUS][ST_PIE],
                                  cr[CR_STATUS][ST_PK]};
            pend <= (pend && !(exc && cause == C_TIMER)) || tick;
        end
    end

endmodule

// File: rtl/risc_cpu.sv
// Single-cycle RiSC-16 core with kernel/user modes, traps and timer interrupt.
// Exceptions are resolved combinationally and suppress the offending instruction.
module risc_cpu #(
    parameter int          MEM_WORDS = risc_pkg::MEM_WORDS,
    parameter logic [15:0] USER_BASE = risc_pkg::USER_BASE
) (
    input logic clk,
    input logic reset
);
    import risc_pkg::*;

    logic [15:0] pc, pc_nx, instr, ddata;
    logic [15:0] rb_v, rx_v, cr_v, simm, addr;
    logic [15:0] epc, epc_q, hvec, wd;
    logic [2:0]  fa, fb, fc, rx_a;
    logic [6:0]  sub;
    opcode_e     op;
    cause_e      cause;
    logic        we, mem_we, cr_we, rfe, exc;
    logic        kmode, ie, pend;
    logic        is_mem, prot, ill, legal, priv;

    assign op   = opcode_e'(instr[15:13]);
    assign fa   = instr[12:10];
    assign fb   = instr[9:7];
    assign fc   = instr[2:0];
    assign sub  = instr[6:0];
    assign simm = sext7(sub);
    assign addr = rb_v + simm;
    assign rx_a = (op == OP_ADD || op == OP_NAND) ? fc : fa;

    assign is_mem = (op == OP_SW) || (op == OP_LW);
    assign prot   = !kmode && (pc < USER_BASE ||
                    (is_mem && addr < USER_BASE));
    assign legal  = sub inside {SUB_JALR, SUB_TRAP, SUB_RFE,
                                SUB_MFC, SUB_MTC, SUB_HALT};
    assign priv   = sub inside {SUB_RFE, SUB_MFC, SUB_MTC, SUB_HALT};
    assign ill    = (op == OP_JALR) && (!legal || (!kmode && priv));

    always_comb begin
        cause = C_NONE;
        if (pend && ie)
            cause = C_TIMER;
        else if (prot)
            cause = C_PROT;
        else if (ill)
            cause = C_ILL;
        else if (op == OP_JALR && sub == SUB_TRAP)
            cause = C_TRAP;
    end

    assign exc = (cause != C_NONE);
    assign epc = (cause == C_TRAP) ? pc + 16'd1 : pc;

    always_comb begin
        pc_nx  = pc + 16'd1;
        we     = 1'b0;
        wd     = 16'd0;
        mem_we = 1'b0;
        cr_we  = 1'b0;
        rfe    = 1'b0;
        if (exc) begin
            pc_nx = hvec;
        end else begin
            unique case (op)
                OP_ADD:  begin we = 1'b1; wd = rb_v + rx_v; end
                OP_ADDI: begin we = 1'b1; wd = rb_v + simm; end
                OP_NAND: begin we = 1'b1; wd = ~(rb_v & rx_v); end
                OP_LUI:  begin we = 1'b1; wd = {instr[9:0], 6'd0}; end
                OP_SW:   mem_we = 1'b1;
                OP_LW:   begin we = 1'b1; wd = ddata; end
                OP_BEQ:  if (rx_v == rb_v) pc_nx = pc + 16'd1 + simm;
                OP_JALR: begin
                    unique case (sub)
                        SUB_JALR: begin
                            we = 1'b1;
                            wd = pc + 16'd1;
                            pc_nx = rb_v;
                        end
                        SUB_RFE:  begin rfe = 1'b1; pc_nx = epc_q; end
                        SUB_MFC:  begin we = 1'b1; wd = cr_v; end
                        SUB_MTC:  cr_we = 1'b1;
                        SUB_HALT: pc_nx = pc;
                        default:  ;
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) pc <= 16'd0;
        else       pc <= pc_nx;
    end

    risc_mem #(.WORDS(MEM_WORDS)) MEM (
        .clk   (clk),
        .iaddr (pc),
        .idata (instr),
        .daddr (addr),
        .ddata (ddata),
        .we    (mem_we && !reset),
        .wdata (rx_v)
    );

    risc_regfile RF (
        .clk   (clk),
        .reset (reset),
        .ra1   (fb),
        .rd1   (rb_v),
        .ra2   (rx_a),
        .rd2   (rx_v),
        .we    (we),
        .wa    (fa),
        .wd    (wd),
        .cr_ra (fb),
        .cr_rd (cr_v),
        .cr_we (cr_we),
        .cr_wa (fa),
        .cr_wd (rb_v),
        .exc   (exc),
        .cause (cause),
        .epc   (epc),
        .rfe   (rfe),
        .kmode (kmode),
        .ie    (ie),
        .epc_q (epc_q),
        .hvec  (hvec),
        .pend  (pend)
    );

endmodule

// File: tb/tb_risc_cpu.sv
// Bench for risc_cpu: directed programs with fixed expectations plus random
// programs run in lockstep with an instruction-level reference model.
module tb_risc_cpu;

    logic clk;
    logic reset;

    risc_cpu cpu (.clk(clk), .reset(reset));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    logic [15:0] mm  [0:65535];
    logic [15:0] mr  [0:7];
    logic [15:0] mcr [0:7];
    logic [15:0] mpc;
    bit          mpend;
    logic [15:0] memq [$];

    function automatic logic [15:0] I(input int op, input int a,
                                      input int b, input int imm);
        logic [2:0] o3, a3, b3;
        logic [6:0] i7;
        o3 = 3'(op); a3 = 3'(a); b3 = 3'(b); i7 = 7'(imm);
        return {o3, a3, b3, i7};
    endfunction

    function automatic logic [15:0] R(input int op, input int a,
                                      input int b, input int c);
        logic [2:0] o3, a3, b3, c3;
        o3 = 3'(op); a3 = 3'(a); b3 = 3'(b); c3 = 3'(c);
        return {o3, a3, b3, 4'd0, c3};
    endfunction

    function automatic logic [15:0] U(input int op, input int a,
                                      input int imm);
        logic [2:0] o3, a3;
        logic [9:0] i10;
        o3 = 3'(op); a3 = 3'(a); i10 = 10'(imm);
        return {o3, a3, i10};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) begin
            cpu.MEM.m[i] = 16'd0;
            mm[i] = 16'd0;
        end
    endtask

    task automatic load(input int addr, input logic [15:0] w);
        cpu.MEM.m[addr] = w;
        mm[addr] = w;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mpc = 16'd0;
        mpend = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mr[i] = 16'd0;
            mcr[i] = 16'd0;
        end
        mcr[0] = 16'h0001;
        memq.delete();
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] v);
        if (a != 3'd0) mr[a] = v;
    endtask

    // One instruction per call, straight from the ISA rules.
    task automatic m_step();
        logic [15:0] ins, ra, rb, rc, simm, addr, nxt, crv;
        logic [2:0]  op, a, b, c;
        logic [6:0]  sub;
        int          cause;
        bit          fire, kern, ie, legal, priv;
        ins  = mm[mpc];
        op   = ins[15:13];
        a    = ins[12:10];
        b    = ins[9:7];
        c    = ins[2:0];
        sub  = ins[6:0];
        simm = {{9{ins[6]}}, ins[6:0]};
        ra   = mr[a];
        rb   = mr[b];
        rc   = mr[c];
        crv  = mcr[b];
        addr = rb + simm;
        kern = mcr[0][0];
        ie   = mcr[0][1];
        legal = sub inside {7'h0, 7'h1, 7'h2, 7'h3, 7'h4, 7'h7F};
        priv  = sub inside {7'h2, 7'h3, 7'h4, 7'h7F};
        cause = 0;
        if (mpend && ie)
            cause = 4;
        else if (!kern && (mpc < 16'h0300 ||
                 ((op == 4 || op == 5) && addr < 16'h0300)))
            cause = 3;
        else if (op == 7 && (!legal || (!kern && priv)))
            cause = 2;
        else if (op == 7 && sub == 7'h1)
            cause = 1;
        fire = (mcr[4] == 16'd1);
        if (mcr[4] != 16'd0) mcr[4] = mcr[4] - 16'd1;
        nxt = mpc + 16'd1;
        if (cause != 0) begin
            mcr[1] = (cause == 1) ? mpc + 16'd1 : mpc;
            mcr[2] = 16'(cause);
            mcr[0][3] = ie;
            mcr[0][2] = kern;
            mcr[0][1] = 1'b0;
            mcr[0][0] = 1'b1;
            nxt = mcr[5];
        end else begin
            case (op)
                3'd0: wr(a, rb + rc);
                3'd1: wr(a, rb + simm);
                3'd2: wr(a, ~(rb & rc));
                3'd3: wr(a, {ins[9:0], 6'd0});
                3'd4: begin mm[addr] = ra; memq.push_back(addr); end
                3'd5: wr(a, mm[addr]);
                3'd6: if (ra == rb) nxt = mpc + 16'd1 + simm;
                default: begin
                    case (sub)
                        7'h0: begin wr(a, mpc + 16'd1); nxt = rb; end
                        7'h2: begin
                            nxt = mcr[1];
                            mcr[0][0] = mcr[0][2];
                            mcr[0][1] = mcr[0][3];
                        end
                        7'h3: wr(a, crv);
                        7'h4: begin
                            mcr[a] = rb;
                            if (a == 3'd4) fire = 1'b0;
                        end
                        7'h7F: nxt = mpc;
                        default: ;
                    endcase
                end
            endcase
        end
        mpend = (mpend && cause != 4) || fire;
        mpc = nxt;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            m_step();
            #1;
            chk("pc", cpu.pc, mpc);
            for (int i = 1; i < 8; i++)
                chk($sformatf("r%0d", i), cpu.RF.r[i], mr[i]);
            for (int i = 0; i < 8; i++)
                chk($sformatf("cr%0d", i), cpu.RF.cr[i], mcr[i]);
        end
    endtask

    function automatic logic [15:0] rand_ins();
        logic [15:0] w;
        w = 16'($urandom);
        if (w[15:13] == 3'd7) begin
            case ($urandom_range(0, 6))
                0: w[6:0] = 7'h00;
                1: w[6:0] = 7'h01;
                2: w[6:0] = 7'h02;
                3: w[6:0] = 7'h03;
                4: w[6:0] = 7'h04;
                5: w[6:0] = 7'h7F;
                default: w[6:0] = 7'($urandom);
            endcase
        end
        return w;
    endfunction

    task automatic user_prog(input logic [15:0] w300,
                             input logic [15:0] w301);
        clear_mem();
        load(0, I(1, 1, 0, 16'h10));
        load(1, I(7, 5, 1, 4));
        load(2, U(3, 2, 16'h00C));
        load(3, I(7, 1, 2, 4));
        load(4, I(7, 0, 0, 2));
        load(16'h10, I(7, 0, 0, 2));
        load(16'h300, w300);
        load(16'h301, w301);
    endtask

    task automatic timer_prog(input int ie0);
        clear_mem();
        load(0, I(1, 1, 0, 16'h30));
        load(1, I(7, 5, 1, 4));
        load(2, I(1, 2, 0, 9));
        load(3, I(1, 3, 0, ie0 ? 3 : 1));
        load(4, I(7, 4, 2, 4));
        load(5, I(7, 0, 3, 4));
        load(20, I(1, 3, 0, 3));
        load(21, I(7, 0, 3, 4));
    endtask

    initial begin
        reset = 1'b1;

        // reset state and ALU
        clear_mem();
        load(0, I(1, 1, 0, 5));
        load(1, R(0, 2, 1, 1));
        do_reset();
        #1;
        chk("rst_pc", cpu.pc, 16'd0);
        chk("rst_r1", cpu.RF.r[1], 16'd0);
        chk("rst_cr0", cpu.RF.cr[0], 16'h0001);
        chk("rst_cr4", cpu.RF.cr[4], 16'd0);
        run(2);
        chk("alu_r1", cpu.RF.r[1], 16'd5);
        chk("alu_r2", cpu.RF.r[2], 16'd10);
        chk("alu_pc", cpu.pc, 16'd2);

        // LUI / SW / LW
        clear_mem();
        load(0, U(3, 3, 16'h3FF));
        load(1, I(1, 5, 0, 16'h20));
        load(2, I(4, 3, 5, 16'h20));
        load(3, I(5, 4, 5, 16'h20));
        do_reset();
        run(4);
        chk("lui_r3", cpu.RF.r[3], 16'hFFC0);
        chk("sw_mem", cpu.MEM.m[16'h40], 16'hFFC0);
        chk("lw_r4", cpu.RF.r[4], 16'hFFC0);

        // branch to self, untaken branch, halt
        clear_mem();
        load(0, I(6, 0, 0, 16'h7F));
        do_reset();
        run(3);
        chk("beq_loop_pc", cpu.pc, 16'd0);
        clear_mem();
        load(0, I(1, 1, 0, 1));
        load(1, I(6, 1, 0, 5));
        do_reset();
        run(2);
        chk("beq_ne_pc", cpu.pc, 16'd2);
        clear_mem();
        load(0, I(7, 0, 0, 16'h7F));
        do_reset();
        run(3);
        chk("halt_pc", cpu.pc, 16'd0);

        // TRAP / RFE / protection fault
        user_prog(I(7, 0, 0, 1), I(5, 4, 0, 5));
        do_reset();
        run(5);
        chk("user_pc", cpu.pc, 16'h0300);
        chk("user_cr0", cpu.RF.cr[0], 16'h0000);
        run(1);
        chk("trap_pc", cpu.pc, 16'h0010);
        chk("trap_cr1", cpu.RF.cr[1], 16'h0301);
        chk("trap_cr2", cpu.RF.cr[2], 16'd1);
        chk("trap_cr0", cpu.RF.cr[0], 16'h0001);
        run(1);
        chk("rfe_pc", cpu.pc, 16'h0301);
        chk("rfe_cr0", cpu.RF.cr[0], 16'h0000);
        run(1);
        chk("prot_pc", cpu.pc, 16'h0010);
        chk("prot_cr2", cpu.RF.cr[2], 16'd3);
        chk("prot_cr1", cpu.RF.cr[1], 16'h0301);
        chk("prot_r4", cpu.RF.r[4], 16'd0);

        // privileged instruction in user mode
        user_prog(I(7, 3, 0, 4), 16'd0);
        do_reset();
        run(6);
        chk("priv_pc", cpu.pc, 16'h0010);
        chk("priv_cr2", cpu.RF.cr[2], 16'd2);
        chk("priv_cr1", cpu.RF.cr[1], 16'h0300);

        // timer with IE set
        timer_prog(1);
        do_reset();
        run(14);
        chk("tmr_pre_pc", cpu.pc, 16'd14);
        chk("tmr_cr4", cpu.RF.cr[4], 16'd0);
        chk("tmr_pre_cr2", cpu.RF.cr[2], 16'd0);
        run(1);
        chk("tmr_pc", cpu.pc, 16'h0030);
        chk("tmr_cr2", cpu.RF.cr[2], 16'd4);
        chk("tmr_cr1", cpu.RF.cr[1], 16'd14);
        chk("tmr_cr0", cpu.RF.cr[0], 16'h000D);

        // timer expiry held pending until IE is set
        timer_prog(0);
        do_reset();
        run(22);
        chk("tmr0_pc", cpu.pc, 16'd22);
        chk("tmr0_cr2", cpu.RF.cr[2], 16'd0);
        run(1);
        chk("tmr0_irq_pc", cpu.pc, 16'h0030);
        chk("tmr0_cr2", cpu.RF.cr[2], 16'd4);
        chk("tmr0_cr1", cpu.RF.cr[1], 16'd22);

        // random programs against the model
        for (int rnd = 0; rnd < 6; rnd++) begin
            clear_mem();
            for (int i = 0; i < 48; i++) load(i, rand_ins());
            for (int i = 0; i < 48; i++) load(16'h300 + i, rand_ins());
            do_reset();
            run(150);
            foreach (memq[k])
                chk("rnd_mem", cpu.MEM.m[memq[k]], mm[memq[k]]);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
